// File: rtl/fastica_iter_ctrl.sv
// FastICA one-unit iteration sequencer for the 4x4 Q13.13 W register.
// Per row: update -> normalise -> convergence check; after row 3 the W register is
// loaded and the loop repeats until every row converges or MaxIter is reached.
// Optional feature macro: FASTICA_WATCHDOG_EN adds a per-wait-state watchdog (WdCycles).
module fastica_iter_ctrl #(
  parameter int unsigned        MaxIter  = 16,
  parameter logic signed [25:0] Tol      = 26'sd8,
  parameter int unsigned        WdCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        upd_start_o,
  input  logic        upd_done_i,
  output logic        norm_start_o,
  input  logic        norm_done_i,
  input  logic        conv_valid_i,
  input  logic [25:0] conv_delta_i,
  output logic [1:0]  row_sel_o,
  output logic        w_init_sel_o,
  output logic        w_load_en_o,
  output logic [7:0]  iter_cnt_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        converged_o,
  output logic        timeout_o,
  output logic        wd_err_o
);

  typedef enum logic [3:0] {
    StIdle, StInit, StUpd, StUpdW, StNorm, StNormW, StCheck, StLoad, StFin
  } state_e;

  localparam logic [25:0] TolMag   = Tol;
  localparam logic [7:0]  MaxIterW = 8'(MaxIter);

  state_e      state_q;
  logic        upd_start_q, norm_start_q, w_init_sel_q, w_load_en_q, done_q, busy_q;
  logic        converged_q, timeout_q;
  logic [1:0]  row_sel_q;
  logic [7:0]  iter_cnt_q;
  logic [3:0]  conv_mask_q;
  logic [25:0] delta_abs;
  logic        row_ok;
  logic        wd_fire;

  // Magnitude of the change metric; the most negative value saturates to the largest positive.
  always_comb begin
    if (conv_delta_i == 26'h2000000) begin
      delta_abs = 26'h1FFFFFF;
    end else if (conv_delta_i[25]) begin
      delta_abs = ~conv_delta_i + 26'd1;
    end else begin
      delta_abs = conv_delta_i;
    end
    row_ok = (delta_abs < TolMag);
  end

`ifdef FASTICA_WATCHDOG_EN
  localparam logic [15:0] WdLast = 16'(WdCycles - 1);

  logic [15:0] wd_cnt_q;
  logic        wait_hold;
  logic        wd_err_q;

  // A wait state that will not be left on this edge keeps the watchdog counting.
  assign wait_hold = ((state_q == StUpdW)  && !upd_done_i)  ||
                     ((state_q == StNormW) && !norm_done_i) ||
                     ((state_q == StCheck) && !conv_valid_i);
  assign wd_fire   = wait_hold && (wd_cnt_q == WdLast);

  // Watchdog counter: restarts from zero whenever a wait state is entered or left.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
    end else if (wait_hold && !abort_i && !wd_fire) begin
      wd_cnt_q <= wd_cnt_q + 16'd1;
    end else begin
      wd_cnt_q <= '0;
    end
  end

  // Sticky watchdog error, cleared when a new run starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_err_q <= 1'b0;
    end else if ((state_q == StIdle) && start_i) begin
      wd_err_q <= 1'b0;
    end else if (wd_fire && !abort_i) begin
      wd_err_q <= 1'b1;
    end
  end

  assign wd_err_o = wd_err_q;
`else
  assign wd_fire  = 1'b0;
  assign wd_err_o = 1'b0;
`endif

  // Main sequencer; all outputs are registered alongside the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      upd_start_q  <= 1'b0;
      norm_start_q <= 1'b0;
      w_init_sel_q <= 1'b0;
      w_load_en_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      converged_q  <= 1'b0;
      timeout_q    <= 1'b0;
      row_sel_q    <= 2'd0;
      iter_cnt_q   <= 8'd0;
      conv_mask_q  <= 4'h0;
    end else begin
      upd_start_q  <= 1'b0;
      norm_start_q <= 1'b0;
      w_init_sel_q <= 1'b0;
      w_load_en_q  <= 1'b0;
      done_q       <= 1'b0;
      if ((state_q != StIdle) && abort_i) begin
        state_q <= StIdle;
        busy_q  <= 1'b0;
      end else if (wd_fire) begin
        state_q <= StFin;
        done_q  <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              state_q      <= StInit;
              busy_q       <= 1'b1;
              converged_q  <= 1'b0;
              timeout_q    <= 1'b0;
              w_init_sel_q <= 1'b1;
              w_load_en_q  <= 1'b1;
              iter_cnt_q   <= 8'd0;
              row_sel_q    <= 2'd0;
              conv_mask_q  <= 4'h0;
            end
          end
          StInit: begin
            state_q     <= StUpd;
            upd_start_q <= 1'b1;
          end
          StUpd: begin
            state_q <= StUpdW;
          end
          StUpdW: begin
            if (upd_done_i) begin
              state_q      <= StNorm;
              norm_start_q <= 1'b1;
            end
          end
          StNorm: begin
            state_q <= StNormW;
          end
          StNormW: begin
            if (norm_done_i) begin
              state_q <= StCheck;
            end
          end
          StCheck: begin
            if (conv_valid_i) begin
              conv_mask_q[row_sel_q] <= row_ok;
              if (row_sel_q == 2'd3) begin
                state_q     <= StLoad;
                w_load_en_q <= 1'b1;
              end else begin
                row_sel_q   <= row_sel_q + 2'd1;
                state_q     <= StUpd;
                upd_start_q <= 1'b1;
              end
            end
          end
          StLoad: begin
            iter_cnt_q <= iter_cnt_q + 8'd1;
            row_sel_q  <= 2'd0;
            if (conv_mask_q == 4'hF) begin
              converged_q <= 1'b1;
              state_q     <= StFin;
              done_q      <= 1'b1;
            end else if ((iter_cnt_q + 8'd1) == MaxIterW) begin
              timeout_q <= 1'b1;
              state_q   <= StFin;
              done_q    <= 1'b1;
            end else begin
              conv_mask_q <= 4'h0;
              state_q     <= StUpd;
              upd_start_q <= 1'b1;
            end
          end
          StFin: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign upd_start_o  = upd_start_q;
  assign norm_start_o = norm_start_q;
  assign w_init_sel_o = w_init_sel_q;
  assign w_load_en_o  = w_load_en_q;
  assign done_o       = done_q;
  assign busy_o       = busy_q;
  assign converged_o  = converged_q;
  assign timeout_o    = timeout_q;
  assign row_sel_o    = row_sel_q;
  assign iter_cnt_o   = iter_cnt_q;

endmodule
